vga_rect_engine: RTL
====================

Name: vga_rect_engine

Overview:
- Parametrised rectangle drawing engine that produces the game's VGA plot stream (VGA_X, VGA_Y, VGA_COLOR, plot) one pixel per clock.
- Sits between game logic and the VGA adapter, replacing ad-hoc per-object pixel loops.
- Supports all three adapter resolutions and colour depths, and three draw modes: filled rectangle, outline, full-screen clear.
- Clips every operation to the screen and reports completion with a busy/done handshake.

Parameters:
- RESOLUTION, "160x120": one of "640x480", "320x240", "160x120"; sets XMAX/YMAX to 639/479, 319/239, 159/119.
- COLOR_DEPTH, 9: colour bits; legal values 9, 6, 3.
- XW, derived: 10/9/8 for the three resolutions respectively; YW = XW-1.

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- mode  in  2  00 fill, 01 outline, 10 clear screen, 11 no-op.
- x0  in  XW  left column.
- y0  in  YW  top row.
- w  in  XW+1  width in pixels.
- h  in  YW+1  height in pixels.
- color  in  COLOR_DEPTH  draw colour.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse when a command completes.
- VGA_X  out  XW  pixel column.
- VGA_Y  out  YW  pixel row.
- VGA_COLOR  out  COLOR_DEPTH  pixel colour.
- plot  out  1  pixel write enable.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, plot, VGA_X, VGA_Y, VGA_COLOR all 0. Reset mid-draw aborts the command with no done pulse.
- States: IDLE, DRAW, FIN.
- IDLE, start=1 at edge t: latch mode and color, compute the bounds below, busy=1 from t.
  - Empty command goes to FIN.
  - Otherwise goes to DRAW with the scan position at (xs,ys).
- start while busy or in FIN is ignored; the latched operands do not change.
- Bounds, computed at XW+1/YW+1 bits with no wrap:
  - Fill/outline: xs=x0, ys=y0, xe=min(x0+w-1,XMAX), ye=min(y0+h-1,YMAX).
  - Clear: xs=0, ys=0, xe=XMAX, ye=YMAX; x0, y0, w, h are ignored.
  - Empty command: w==0, h==0, x0>XMAX, y0>YMAX, or mode 11.
- DRAW: raster order, x increments first and wraps to xs with y+1. One position per cycle; the first position is presented at t+1.
  - Each cycle registers VGA_X/VGA_Y to the position and VGA_COLOR=color.
  - plot=1 for fill/clear. For outline, plot=1 only if x==xs, x==xe, y==ys or y==ye; interior positions are still scanned with plot=0.
  - After (xe,ye) is presented, go to FIN.
- Outline with a width-1 or height-1 bound plots every pixel.
- FIN: lasts one cycle: done=1, busy=0, plot=0; then IDLE.
- Timing, N = (xe-xs+1)*(ye-ys+1):
  - Pixels are presented on cycles t+1..t+N and done fires at t+N+1.
  - Empty command: done fires at t+1 with no plot.
- VGA_X/VGA_Y/VGA_COLOR hold their last values when plot=0.

Test Plan:
- 160x120, fill x0=10 y0=20 w=3 h=2 color=9'h1FF -> plot on 6 consecutive cycles: (10,20)(11,20)(12,20)(10,21)(11,21)(12,21); done at t+7; busy high t..t+6.
- Outline x0=0 y0=0 w=4 h=3 -> 12 scan cycles, plot low only at (1,1) and (2,1); 10 pixels plotted; done at t+13.
- Clip: fill x0=158 y0=118 w=5 h=5 -> pixels (158,118)(159,118)(158,119)(159,119) only; done at t+5.
- Clear, color=0, 160x120 -> 19200 plots ending at (159,119); done at t+19201. Repeat at 320x240 -> last pixel (319,239).
- Empty: w=0, and separately x0=200 -> no plot; done at t+1. A start during DRAW is ignored and the scan does not change.
- Assert reset at the 5th pixel of a 6-pixel fill -> outputs 0 immediately, no done. A new start after release runs normally.

Source files
------------

// File: rtl/vga_rect_engine_if.sv
// Command and pixel-stream bundle between game logic and the rectangle engine.
// The master issues draw commands; the slave answers with busy/done and the plot stream.
interface vga_rect_engine_if #(
    parameter int XW = 8,
    parameter int CD = 9
);
    localparam int YW = XW - 1;

    logic          start;
    logic [1:0]    mode;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW:0]   w;
    logic [YW:0]   h;
    logic [CD-1:0] color;
    logic          busy;
    logic          done;
    logic [XW-1:0] VGA_X;
    logic [YW-1:0] VGA_Y;
    logic [CD-1:0] VGA_COLOR;
    logic          plot;

    modport master (
        output start, mode, x0, y0, w, h, color,
        input  busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
    );

    modport slave (
        input  start, mode, x0, y0, w, h, color,
        output busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
    );
endinterface

// File: rtl/vga_rect_engine.sv
// Clipped rectangle engine: fill, outline or clear, one scan position per clock,
// finishing with a single-cycle done pulse.
module vga_rect_engine #(
    parameter string RESOLUTION  = "160x120",
    parameter int    COLOR_DEPTH = 9
) (
    input logic              CLOCK_50,
    input logic              reset,
    vga_rect_engine_if.slave bus
);
    localparam int XW = (RESOLUTION == "640x480") ? 10 :
                        (RESOLUTION == "320x240") ? 9 : 8;
    localparam int YW = XW - 1;
    localparam int XMAX = (RESOLUTION == "640x480") ? 639 :
                          (RESOLUTION == "320x240") ? 319 : 159;
    localparam int YMAX = (RESOLUTION == "640x480") ? 479 :
                          (RESOLUTION == "320x240") ? 239 : 119;

    localparam logic [XW-1:0] XM = XMAX[XW-1:0];
    localparam logic [YW-1:0] YM = YMAX[YW-1:0];
    localparam logic [XW+1:0] XL = XMAX[XW+1:0];
    localparam logic [YW+1:0] YL = YMAX[YW+1:0];

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t                 state;
    logic [1:0]             md;
    logic [COLOR_DEPTH-1:0] col;
    logic [XW-1:0]          xs, xe, cx;
    logic [YW-1:0]          ys, ye, cy;

    logic                   busy_q, done_q, plot_q;
    logic [XW-1:0]          vx_q;
    logic [YW-1:0]          vy_q;
    logic [COLOR_DEPTH-1:0] vc_q;

    logic [XW+1:0] x_end;
    logic [YW+1:0] y_end;
    logic [XW-1:0] bxs, bxe;
    logic [YW-1:0] bys, bye;
    logic          clr, empty;

    // Extra headroom bits keep x0+w-1 from wrapping before the clip.
    always_comb begin
        x_end = {2'b00, bus.x0} + {1'b0, bus.w} - 1'b1;
        y_end = {2'b00, bus.y0} + {1'b0, bus.h} - 1'b1;
        clr   = (bus.mode == 2'b10);
        empty = (bus.mode == 2'b11) ||
                (!clr && (bus.w == '0 || bus.h == '0 ||
                          bus.x0 > XM || bus.y0 > YM));
        bxs = clr ? '0 : bus.x0;
        bys = clr ? '0 : bus.y0;
        bxe = (clr || x_end > XL) ? XM : x_end[XW-1:0];
        bye = (clr || y_end > YL) ? YM : y_end[YW-1:0];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            md     <= '0;
            col    <= '0;
            xs     <= '0;
            xe     <= '0;
            ys     <= '0;
            ye     <= '0;
            cx     <= '0;
            cy     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            plot_q <= 1'b0;
            vx_q   <= '0;
            vy_q   <= '0;
            vc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    plot_q <= 1'b0;
                    if (bus.start) begin
                        md     <= bus.mode;
                        col    <= bus.color;
                        xs     <= bxs;
                        xe     <= bxe;
                        ys     <= bys;
                        ye     <= bye;
                        cx     <= bxs;
                        cy     <= bys;
                        busy_q <= 1'b1;
                        state  <= empty ? FIN : DRAW;
                    end
                end
                DRAW: begin
                    vx_q   <= cx;
                    vy_q   <= cy;
                    vc_q   <= col;
                    // Outline scans the interior too, just without plotting it.
                    plot_q <= (md != 2'b01) || cx == xs || cx == xe ||
                              cy == ys || cy == ye;
                    if (cx == xe) begin
                        cx <= xs;
                        if (cy == ye)
                            state <= FIN;
                        else
                            cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                FIN: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.plot      = plot_q;
    assign bus.VGA_X     = vx_q;
    assign bus.VGA_Y     = vy_q;
    assign bus.VGA_COLOR = vc_q;
endmodule
